// File: rtl/traffic_light_pkg.sv
// Shared phase/lamp encodings and default phase durations for the traffic
// light controller and its checker.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_t;

  // Lamp codes are {red, yellow, green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int DEF_RED_CYCLES    = 10;
  localparam int DEF_GREEN_CYCLES  = 8;
  localparam int DEF_YELLOW_CYCLES = 3;

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Combinational lamp-code decoder: one-hot {red, yellow, green} to phase,
// with every non-one-hot code (including all-off) flagged illegal.
module tl_lamp_decode
  import traffic_light_pkg::*;
(
  input  logic [2:0] lamp,
  output phase_t     phase,
  output logic       illegal
);

  always_comb begin
    phase   = PH_SYNC;
    illegal = 1'b0;
    case (lamp)
      LAMP_RED:    phase = PH_RED;
      LAMP_GREEN:  phase = PH_GREEN;
      LAMP_YELLOW: phase = PH_YELLOW;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_checker.sv
// Passive observer of the traffic light lamp interface: tracks the phase
// sequence, measures dwell per phase and keeps sticky error flags.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   PH_SYNC   | no trusted phase; waiting for the first legal lamp code
//   PH_RED    | tracking a RED dwell
//   PH_GREEN  | tracking a GREEN dwell
//   PH_YELLOW | tracking a YELLOW dwell
module traffic_light_checker
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int TOL           = 0,
  parameter int CNT_W         = 8,
  parameter int CYC_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_order,
  output logic             err_dwell,
  output logic             err_any,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int MAX_CYC = (RED_CYCLES > GREEN_CYCLES)
                         ? ((RED_CYCLES > YELLOW_CYCLES) ? RED_CYCLES : YELLOW_CYCLES)
                         : ((GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES);

  if (TOL >= RED_CYCLES || TOL >= GREEN_CYCLES || TOL >= YELLOW_CYCLES) begin : g_bad_tol
    $error("TOL must be smaller than every phase duration");
  end
  if (longint'(MAX_CYC + TOL + 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the longest dwell plus tolerance");
  end

  localparam logic [CNT_W-1:0] RED_LO     = CNT_W'(RED_CYCLES - TOL);
  localparam logic [CNT_W-1:0] RED_OVF    = CNT_W'(RED_CYCLES + TOL + 1);
  localparam logic [CNT_W-1:0] GREEN_LO   = CNT_W'(GREEN_CYCLES - TOL);
  localparam logic [CNT_W-1:0] GREEN_OVF  = CNT_W'(GREEN_CYCLES + TOL + 1);
  localparam logic [CNT_W-1:0] YELLOW_LO  = CNT_W'(YELLOW_CYCLES - TOL);
  localparam logic [CNT_W-1:0] YELLOW_OVF = CNT_W'(YELLOW_CYCLES + TOL + 1);

  phase_t             phase_q, phase_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               partial_q, partial_d;
  logic               locked_q, locked_d;
  logic               err_illegal_q, err_illegal_d;
  logic               err_order_q, err_order_d;
  logic               err_dwell_q, err_dwell_d;
  logic               err_any_q, err_any_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;

  phase_t             lamp_ph;
  logic               lamp_illegal;
  logic [CNT_W-1:0]   exp_lo, exp_ovf, dwell_inc;
  logic               set_illegal, set_order, set_dwell;

  tl_lamp_decode u_decode (
    .lamp    ({red, yellow, green}),
    .phase   (lamp_ph),
    .illegal (lamp_illegal)
  );

  always_comb begin
    exp_lo  = '0;
    exp_ovf = '1;
    case (phase_q)
      PH_RED:    begin exp_lo = RED_LO;    exp_ovf = RED_OVF;    end
      PH_GREEN:  begin exp_lo = GREEN_LO;  exp_ovf = GREEN_OVF;  end
      PH_YELLOW: begin exp_lo = YELLOW_LO; exp_ovf = YELLOW_OVF; end
      default:   ;
    endcase
  end

  // Dwell saturates so a stuck lamp cannot wrap back into the legal window
  assign dwell_inc = (&dwell_q) ? dwell_q : dwell_q + CNT_W'(1);

  always_comb begin
    phase_d       = phase_q;
    dwell_d       = dwell_q;
    partial_d     = partial_q;
    locked_d      = locked_q;
    cycle_count_d = cycle_count_q;
    set_illegal   = 1'b0;
    set_order     = 1'b0;
    set_dwell     = 1'b0;

    if (phase_q == PH_SYNC) begin
      if (lamp_illegal) begin
        set_illegal = 1'b1;
      end else begin
        phase_d   = lamp_ph;
        dwell_d   = CNT_W'(1);
        partial_d = 1'b1;
      end
    end else if (lamp_illegal) begin
      set_illegal = 1'b1;
      phase_d     = PH_SYNC;
      dwell_d     = '0;
      partial_d   = 1'b1;
      locked_d    = 1'b0;
    end else if (lamp_ph == phase_q) begin
      dwell_d = dwell_inc;
      if (!(&dwell_q) && dwell_inc == exp_ovf) set_dwell = 1'b1;
    end else begin
      // Long dwells were already caught by the overstay compare above
      if (!partial_q && dwell_q < exp_lo) set_dwell = 1'b1;
      if (lamp_ph != next_phase(phase_q)) set_order = 1'b1;
      if (phase_q == PH_YELLOW && lamp_ph == PH_RED && locked_q)
        cycle_count_d = cycle_count_q + CYC_W'(1);
      phase_d   = lamp_ph;
      dwell_d   = CNT_W'(1);
      partial_d = 1'b0;
      locked_d  = 1'b1;
    end

    err_illegal_d = set_illegal | (err_illegal_q & ~clr_err);
    err_order_d   = set_order   | (err_order_q   & ~clr_err);
    err_dwell_d   = set_dwell   | (err_dwell_q   & ~clr_err);
    err_any_d     = err_illegal_d | err_order_d | err_dwell_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q       <= PH_SYNC;
      dwell_q       <= '0;
      partial_q     <= 1'b1;
      locked_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_order_q   <= 1'b0;
      err_dwell_q   <= 1'b0;
      err_any_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      partial_q     <= partial_d;
      locked_q      <= locked_d;
      err_illegal_q <= err_illegal_d;
      err_order_q   <= err_order_d;
      err_dwell_q   <= err_dwell_d;
      err_any_q     <= err_any_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = locked_q;
  assign err_illegal = err_illegal_q;
  assign err_order   = err_order_q;
  assign err_dwell   = err_dwell_q;
  assign err_any     = err_any_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_checker.sv
// Bench for traffic_light_checker: directed vector table followed by a
// randomized lamp stream compared against a behavioural model.
module tb_traffic_light_checker;
  import traffic_light_pkg::*;

  localparam int TOL   = 0;
  localparam int CYC_W = 16;
  localparam int DW_MAX = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             red = 1'b0, yellow = 1'b0, green = 1'b0, clr_err = 1'b0;
  logic [1:0]       phase;
  logic             locked, err_illegal, err_order, err_dwell, err_any;
  logic [CYC_W-1:0] cycle_count;

  always #5 clk = ~clk;

  traffic_light_checker #(
    .RED_CYCLES(10), .GREEN_CYCLES(8), .YELLOW_CYCLES(3),
    .TOL(TOL), .CNT_W(8), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
    .clr_err(clr_err), .phase(phase), .locked(locked),
    .err_illegal(err_illegal), .err_order(err_order), .err_dwell(err_dwell),
    .err_any(err_any), .cycle_count(cycle_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
  endtask

  task automatic drive(input bit rn, input logic [2:0] code, input bit clr);
    rst = rn;
    {red, yellow, green} = code;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: colours 0=none 1=red 2=green 3=yellow
  int exp_c[4]    = '{0, 10, 8, 3};
  int succ[4]     = '{0, 2, 3, 1};
  logic [2:0] col_code[4] = '{3'b000, 3'b100, 3'b001, 3'b010};
  int m_ph, m_dw, m_part, m_lock, m_ill, m_ord, m_dwl, m_cc;

  function automatic int colour_of(input logic [2:0] c);
    case (c)
      3'b100:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit rn, input logic [2:0] code, input bit clr);
    int col;
    int n_ill, n_ord, n_dwl;
    if (!rn) begin
      m_ph = 0; m_dw = 0; m_part = 1; m_lock = 0;
      m_ill = 0; m_ord = 0; m_dwl = 0; m_cc = 0;
      return;
    end
    col = colour_of(code);
    n_ill = 0; n_ord = 0; n_dwl = 0;
    if (col == 0) begin
      n_ill = 1;
      m_ph = 0; m_dw = 0; m_part = 1; m_lock = 0;
    end else if (m_ph == 0) begin
      m_ph = col; m_dw = 1; m_part = 1;
    end else if (col == m_ph) begin
      if (m_dw < DW_MAX) begin
        m_dw++;
        if (m_dw == exp_c[m_ph] + TOL + 1) n_dwl = 1;
      end
    end else begin
      if (!m_part && m_dw < exp_c[m_ph] - TOL) n_dwl = 1;
      if (col != succ[m_ph]) n_ord = 1;
      if (m_ph == 3 && col == 1 && m_lock) m_cc = (m_cc + 1) % (1 << CYC_W);
      m_ph = col; m_dw = 1; m_part = 0; m_lock = 1;
    end
    m_ill = n_ill | (m_ill & int'(!clr));
    m_ord = n_ord | (m_ord & int'(!clr));
    m_dwl = n_dwl | (m_dwl & int'(!clr));
  endtask

  task automatic check_model();
    chk("rand_phase",   32'(phase),       32'(m_ph));
    chk("rand_locked",  32'(locked),      32'(m_lock));
    chk("rand_illegal", 32'(err_illegal), 32'(m_ill));
    chk("rand_order",   32'(err_order),   32'(m_ord));
    chk("rand_dwell",   32'(err_dwell),   32'(m_dwl));
    chk("rand_any",     32'(err_any),     32'(m_ill | m_ord | m_dwl));
    chk("rand_cycles",  32'(cycle_count), 32'(m_cc));
  endtask

  typedef struct {
    bit         rst_n;
    logic [2:0] lamp;
    bit         clr;
    int         reps;
    int         e_phase;
    bit         e_lock, e_ill, e_ord, e_dwl;
    int         e_cc;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl[NV];

  initial begin
    // rst_n lamp clr reps | phase lock ill ord dwl cc
    tbl[0]  = '{1'b0, 3'b000, 1'b0, 2,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 3'b100, 1'b0, 10, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 3'b001, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 3'b001, 1'b0, 7,  2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 3'b010, 1'b0, 3,  3, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 3'b100, 1'b0, 10, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b1, 3'b001, 1'b0, 8,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b1, 3'b010, 1'b0, 3,  3, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1, 3'b100, 1'b0, 10, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[9]  = '{1'b1, 3'b001, 1'b0, 8,  2, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[10] = '{1'b1, 3'b010, 1'b0, 3,  3, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b1, 3'b100, 1'b0, 10, 1, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    tbl[12] = '{1'b1, 3'b001, 1'b0, 8,  2, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    tbl[13] = '{1'b1, 3'b010, 1'b0, 3,  3, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    tbl[14] = '{1'b1, 3'b100, 1'b0, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[15] = '{1'b1, 3'b100, 1'b0, 9,  1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    // short GREEN
    tbl[16] = '{1'b1, 3'b001, 1'b0, 7,  2, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[17] = '{1'b1, 3'b010, 1'b0, 1,  3, 1'b1, 1'b0, 1'b0, 1'b1, 4};
    tbl[18] = '{1'b1, 3'b010, 1'b1, 1,  3, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[19] = '{1'b1, 3'b010, 1'b0, 1,  3, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    // RED overstay fires on the 11th sample and only once
    tbl[20] = '{1'b1, 3'b100, 1'b0, 10, 1, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    tbl[21] = '{1'b1, 3'b100, 1'b0, 1,  1, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    tbl[22] = '{1'b1, 3'b100, 1'b1, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    tbl[23] = '{1'b1, 3'b001, 1'b0, 8,  2, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    // order then illegal then partial GREEN
    tbl[24] = '{1'b1, 3'b100, 1'b0, 1,  1, 1'b1, 1'b0, 1'b1, 1'b0, 5};
    tbl[25] = '{1'b1, 3'b110, 1'b0, 1,  0, 1'b0, 1'b1, 1'b1, 1'b0, 5};
    tbl[26] = '{1'b1, 3'b001, 1'b0, 5,  2, 1'b0, 1'b1, 1'b1, 1'b0, 5};
    tbl[27] = '{1'b1, 3'b010, 1'b0, 1,  3, 1'b1, 1'b1, 1'b1, 1'b0, 5};
    tbl[28] = '{1'b1, 3'b010, 1'b0, 1,  3, 1'b1, 1'b1, 1'b1, 1'b0, 5};
    tbl[29] = '{1'b1, 3'b100, 1'b0, 1,  1, 1'b1, 1'b1, 1'b1, 1'b1, 6};
    // clr_err colliding with a new illegal sample
    tbl[30] = '{1'b1, 3'b011, 1'b1, 1,  0, 1'b0, 1'b1, 1'b0, 1'b0, 6};
    tbl[31] = '{1'b1, 3'b010, 1'b0, 2,  3, 1'b0, 1'b1, 1'b0, 1'b0, 6};
    // reset mid-YELLOW
    tbl[32] = '{1'b0, 3'b010, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[33] = '{1'b1, 3'b100, 1'b0, 1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    for (int v = 0; v < NV; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) drive(tbl[v].rst_n, tbl[v].lamp, tbl[v].clr);
      chk($sformatf("v%0d_phase", v),   32'(phase),       32'(tbl[v].e_phase));
      chk($sformatf("v%0d_locked", v),  32'(locked),      32'(tbl[v].e_lock));
      chk($sformatf("v%0d_illegal", v), 32'(err_illegal), 32'(tbl[v].e_ill));
      chk($sformatf("v%0d_order", v),   32'(err_order),   32'(tbl[v].e_ord));
      chk($sformatf("v%0d_dwell", v),   32'(err_dwell),   32'(tbl[v].e_dwl));
      chk($sformatf("v%0d_any", v),     32'(err_any),
          32'(tbl[v].e_ill | tbl[v].e_ord | tbl[v].e_dwl));
      chk($sformatf("v%0d_cycles", v),  32'(cycle_count), 32'(tbl[v].e_cc));
    end

    // Randomized lamp stream against the reference model
    begin
      int cur_col;
      drive(1'b0, 3'b000, 1'b0);
      model_step(1'b0, 3'b000, 1'b0);
      check_model();
      cur_col = 0;
      for (int s = 0; s < 350; s++) begin
        int r, col, len;
        bit rn;
        logic [2:0] code;
        r  = int'($urandom_range(0, 99));
        rn = 1'b1;
        if (r < 3) begin
          rn = 1'b0; code = col_code[$urandom_range(0, 3)]; len = 1; col = 0;
        end else if (r < 9) begin
          code = 3'($urandom_range(0, 7));
          col  = colour_of(code);
          len  = (col == 0) ? 1 : exp_c[col];
        end else begin
          if (r < 20 || cur_col == 0) col = int'($urandom_range(1, 3));
          else                        col = succ[cur_col];
          code = col_code[col];
          len  = exp_c[col] + int'($urandom_range(0, 4)) - 2;
          if (len < 1) len = 1;
        end
        for (int c = 0; c < len; c++) begin
          bit clr;
          clr = ($urandom_range(0, 19) == 0);
          drive(rn, code, clr);
          model_step(rn, code, clr);
          check_model();
        end
        cur_col = rn ? col : 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
